// File: rtl/counter_multi.sv
// Multi-channel up/down counter: CHANNELS independent WIDTH-bit counters with
// load clamp, runtime modulo limit, wrap/saturate, terminal-count pulse and sticky overflow.

module counter_multi_lane #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_sat,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic [WIDTH-1:0] i_max_val,
   input  logic             i_ovf_clr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_ovf
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;
   logic [WIDTH-1:0] w_next;
   logic             w_bnd;

   always_comb begin
      w_bnd  = 1'b0;
      w_next = r_count;
      if (i_load) begin
         w_next = (i_load_val > i_max_val) ? i_max_val : i_load_val;
      end else if (i_en) begin
         // A zero limit makes every enabled cycle a boundary, even counting down from a stale value
         if (i_max_val == '0) begin
            w_bnd  = 1'b1;
            w_next = '0;
         end else if (i_dir) begin
            if (r_count < i_max_val) begin
               w_next = r_count + ONE;
            end else begin
               w_bnd  = 1'b1;
               w_next = i_sat ? i_max_val : '0;
            end
         end else if (r_count > i_max_val) begin
            w_next = i_max_val;
         end else if (r_count != '0) begin
            w_next = r_count - ONE;
         end else begin
            w_bnd  = 1'b1;
            w_next = i_sat ? '0 : i_max_val;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_bnd;
         r_ovf   <= w_bnd | (r_ovf & ~i_ovf_clr);
      end
   end

   assign o_count = r_count;
   assign o_tc    = r_tc;
   assign o_ovf   = r_ovf;
endmodule

module counter_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [CHANNELS-1:0]       i_en,
   input  logic [CHANNELS-1:0]       i_dir,
   input  logic [CHANNELS-1:0]       i_sat,
   input  logic [CHANNELS-1:0]       i_load,
   input  logic [CHANNELS*WIDTH-1:0] i_load_val,
   input  logic [CHANNELS*WIDTH-1:0] i_max_val,
   input  logic [CHANNELS-1:0]       i_ovf_clr,
   output logic [CHANNELS*WIDTH-1:0] o_count,
   output logic [CHANNELS-1:0]       o_tc,
   output logic [CHANNELS-1:0]       o_ovf
);
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      counter_multi_lane #(.WIDTH(WIDTH)) u_lane (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_en       (i_en[c]),
         .i_dir      (i_dir[c]),
         .i_sat      (i_sat[c]),
         .i_load     (i_load[c]),
         .i_load_val (i_load_val[c*WIDTH +: WIDTH]),
         .i_max_val  (i_max_val[c*WIDTH +: WIDTH]),
         .i_ovf_clr  (i_ovf_clr[c]),
         .o_count    (o_count[c*WIDTH +: WIDTH]),
         .o_tc       (o_tc[c]),
         .o_ovf      (o_ovf[c])
      );
   end
endmodule

// File: tb/tb_counter_multi.sv
// Self-checking bench for counter_multi: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a per-channel integer model.

module tb_counter_multi;
   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   en, dir, sat, load, ovf_clr;
   logic [N*W-1:0] load_val, max_val;
   logic [N*W-1:0] count;
   logic [N-1:0]   tc, ovf;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;
   int m_cnt [N];
   int m_tc  [N];
   int m_ovf [N];

   counter_multi #(.WIDTH(W), .CHANNELS(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_sat(sat), .i_load(load),
      .i_load_val(load_val), .i_max_val(max_val), .i_ovf_clr(ovf_clr),
      .o_count(count), .o_tc(tc), .o_ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: each channel is a plain integer counter on 0..max following the rules directly
   always @(posedge clk) begin
      for (int c = 0; c < N; c++) begin
         int mv, lv, cur, nc, nt, no;
         mv  = int'(max_val[c*W +: W]);
         lv  = int'(load_val[c*W +: W]);
         cur = m_cnt[c];
         nc  = cur;
         nt  = 0;
         no  = ovf_clr[c] ? 0 : m_ovf[c];
         if (rst) begin
            nc = 0; no = 0;
         end else if (load[c]) begin
            nc = (lv <= mv) ? lv : mv;
         end else if (en[c]) begin
            if (mv == 0) begin
               nc = 0; nt = 1;
            end else if (dir[c]) begin
               if (cur < mv) nc = cur + 1;
               else begin nt = 1; nc = sat[c] ? mv : 0; end
            end else begin
               if (cur > mv) nc = mv;
               else if (cur > 0) nc = cur - 1;
               else begin nt = 1; nc = sat[c] ? 0 : mv; end
            end
            if (nt == 1) no = 1;
         end
         m_cnt[c] <= nc;
         m_tc[c]  <= nt;
         m_ovf[c] <= no;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int c = 0; c < N; c++) begin
            chk($sformatf("model.count[%0d]", c), int'(count[c*W +: W]), m_cnt[c]);
            chk($sformatf("model.tc[%0d]", c),    int'(tc[c]),           m_tc[c]);
            chk($sformatf("model.ovf[%0d]", c),   int'(ovf[c]),          m_ovf[c]);
         end
      end
   end

   task automatic idle();
      en = '0; dir = '0; sat = '0; load = '0; ovf_clr = '0; rst = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int cnt_of(input int c);
      return int'(count[c*W +: W]);
   endfunction

   initial begin
      int exp_up [8];
      int exp_dn [5];
      exp_up = '{1, 2, 3, 4, 5, 0, 1, 2};
      exp_dn = '{1, 0, 0, 0, 0};
      idle();
      load_val = '0;
      max_val  = '0;
      rst = 1'b1;
      step(); step();
      chk_on = 1'b1;
      chk("reset.count", int'(count), 0);
      chk("reset.tc", int'(tc), 0);
      chk("reset.ovf", int'(ovf), 0);

      // ch0 up-wrap with limit 5
      idle();
      max_val[0*W +: W] = 8'd5;
      en[0] = 1'b1; dir[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("upwrap.count", cnt_of(0), exp_up[i]);
         chk("upwrap.tc", int'(tc[0]), (i == 5) ? 1 : 0);
         chk("upwrap.ovf", int'(ovf[0]), (i >= 5) ? 1 : 0);
      end

      // ch1 load 2 then down-saturate
      idle();
      max_val[1*W +: W] = 8'd255;
      load_val[1*W +: W] = 8'd2;
      load[1] = 1'b1;
      step();
      chk("dnsat.load", cnt_of(1), 2);
      load[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b0; sat[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("dnsat.count", cnt_of(1), exp_dn[i]);
         chk("dnsat.tc", int'(tc[1]), (i >= 2) ? 1 : 0);
      end

      // ch2 load clamp beats enable, then wrap
      idle();
      max_val[2*W +: W] = 8'd10;
      load_val[2*W +: W] = 8'd200;
      load[2] = 1'b1; en[2] = 1'b1; dir[2] = 1'b1;
      step();
      chk("clamp.count", cnt_of(2), 10);
      chk("clamp.tc", int'(tc[2]), 0);
      load[2] = 1'b0;
      step();
      chk("clamp.wrap", cnt_of(2), 0);
      chk("clamp.wraptc", int'(tc[2]), 1);

      // ch3 ovf set wins over clear, then clear alone
      idle();
      max_val[3*W +: W] = 8'd3;
      load_val[3*W +: W] = 8'd3;
      load[3] = 1'b1;
      step();
      load[3] = 1'b0; en[3] = 1'b1; dir[3] = 1'b1; ovf_clr[3] = 1'b1;
      step();
      chk("ovfrace.set", int'(ovf[3]), 1);
      en[3] = 1'b0;
      step();
      chk("ovfrace.clr", int'(ovf[3]), 0);

      // ch0 limit lowered below count, then count down
      idle();
      max_val[0*W +: W] = 8'd60;
      load_val[0*W +: W] = 8'd50;
      load[0] = 1'b1;
      step();
      chk("lower.load", cnt_of(0), 50);
      load[0] = 1'b0;
      max_val[0*W +: W] = 8'd20;
      en[0] = 1'b1; dir[0] = 1'b0;
      step();
      chk("lower.clamp", cnt_of(0), 20);
      chk("lower.tc", int'(tc[0]), 0);
      step();
      chk("lower.dec", cnt_of(0), 19);

      // mid-operation reset with every channel enabled
      en = '1; dir = 4'b0101;
      rst = 1'b1;
      step();
      chk("midrst.count", int'(count), 0);
      chk("midrst.tc", int'(tc), 0);
      chk("midrst.ovf", int'(ovf), 0);

      // channel independence: limits 3, 7, 255, 0
      idle();
      max_val = {8'd0, 8'd255, 8'd7, 8'd3};
      en = '1; dir = 4'b1101; sat = 4'b0010;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i % 50 == 0) begin
            chk("indep.ch3count", cnt_of(3), 0);
            chk("indep.ch3tc", int'(tc[3]), 1);
         end
         if (i == 255) chk("indep.ch2top", cnt_of(2), 255);
         if (i == 256) begin
            chk("indep.ch2wrap", cnt_of(2), 0);
            chk("indep.ch2tc", int'(tc[2]), 1);
         end
      end

      // randomized traffic; small limits so boundaries occur often
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         en      = 4'($urandom);
         dir     = 4'($urandom);
         sat     = 4'($urandom);
         load    = 4'($urandom) & 4'($urandom) & 4'($urandom);
         ovf_clr = 4'($urandom) & 4'($urandom);
         load_val = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            for (int c = 0; c < N; c++)
               max_val[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         end
         step();
      end

      idle();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/counter_multi.md
# counter_multi

Parametrised multi-channel up/down counter, the next generation of the team's single `counter` block. Provides CHANNELS independent counters of WIDTH bits. Each channel has:
- enable, direction and load
- a runtime modulo limit
- a selectable wrap or saturate mode
- a registered terminal-count pulse and a sticky overflow flag

It sits behind the same interface-style wrapper as the existing counter and is driven by the class-based driver/checker bench.

## Interface
Parameters:
- WIDTH, 8, bit width of each channel counter (≥ 2)
- CHANNELS, 4, number of independent channels (≥ 1)

Ports (channel c occupies bit c of 1-bit-per-channel buses and bits [c*WIDTH +: WIDTH] of packed buses):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  1 = count up, 0 = count down
- sat  in  CHANNELS  1 = saturate at boundary, 0 = wrap
- load  in  CHANNELS  per-channel load strobe
- load_val  in  CHANNELS*WIDTH  value applied on load
- max_val  in  CHANNELS*WIDTH  per-channel upper limit; count range is 0..max_val
- ovf_clr  in  CHANNELS  clears sticky overflow flag
- count  out  CHANNELS*WIDTH  current count, registered
- tc  out  CHANNELS  terminal-count pulse, registered, one cycle per boundary event
- ovf  out  CHANNELS  sticky overflow flag, registered

## Operation
- Channels are fully independent. No cross-channel interaction.
- Per-channel priority on each rising edge: rst > load > en > hold.
- rst: count = 0, tc = 0, ovf = 0 for all channels, regardless of any other input.
- load = 1:
  - count = load_val when load_val ≤ max_val, else count = max_val (clamp).
  - tc = 0; ovf unchanged except by ovf_clr.
  - en is ignored that cycle.
- en = 1, dir = 1 (up):
  - count < max_val: count + 1, tc = 0.
  - count ≥ max_val is a boundary event. Wrap: count = 0. Saturate: count = max_val. tc = 1 in both modes.
- en = 1, dir = 0 (down):
  - count > max_val (limit lowered at runtime): count = max_val, tc = 0, no boundary event.
  - 0 < count ≤ max_val: count − 1, tc = 0.
  - count == 0 is a boundary event. Wrap: count = max_val. Saturate: count = 0. tc = 1 in both modes.
- en = 0 and load = 0: count holds, tc = 0.
- Saturate mode raises tc and sets ovf on every enabled cycle spent pushing against the boundary.
- ovf:
  - Set on any boundary event.
  - Cleared by ovf_clr.
  - If a boundary event and ovf_clr occur on the same edge, set wins (ovf = 1).
- max_val = 0:
  - count is forced to 0 by any enabled cycle.
  - Every enabled cycle is a boundary event (tc = 1).
- Arithmetic is unsigned, modulo 2^WIDTH internally. Increment/decrement never produces a value outside 0..max_val, except when holding while max_val is lowered.
- max_val, sat and dir are sampled on the same edge as en. Changing them mid-count takes effect on the next enabled edge.

## Timing
- Latency: inputs sampled on edge N; count/tc/ovf reflect them after edge N (visible in cycle N+1).
- tc is high for exactly one cycle per boundary event. Back-to-back boundary events give continuous tc.
- No combinational path from any input to any output.
- Reset asserted mid-count takes effect on the next edge. The first enabled edge after rst deasserts counts from 0.
- Reset values: count = 0, tc = 0, ovf = 0.
- No handshake and no backpressure. Every edge is a potential update.

## Test plan
(All with WIDTH = 8, CHANNELS = 4.)
- Reset then up-wrap, ch0:
  - Stimulus: max_val = 5, sat = 0, dir = 1, en = 1 for 8 cycles.
  - Required: count 1,2,3,4,5,0,1,2; tc high only in the cycle count shows 0; ovf = 1 from then on.
- Down-saturate, ch1:
  - Stimulus: load_val = 2, then en = 1, dir = 0, sat = 1 for 5 cycles.
  - Required: count 2 after load, then 1,0,0,0,0; tc high on each of the last 3 cycles.
- Load clamp and load-over-enable, ch2:
  - Stimulus: max_val = 10, load_val = 200, with load = 1 and en = 1 on the same edge.
  - Required: count = 10, tc = 0, then the next up-count wraps to 0 with tc = 1.
- Sticky ovf set/clear race, ch3:
  - Stimulus: drive a boundary event with ovf_clr = 1 on the same edge, then ovf_clr alone on the next edge.
  - Required: ovf = 1, then ovf = 0.
- Runtime limit lowering plus mid-operation reset:
  - Stimulus, ch0: count at 50 with max_val changed to 20, then dir = 0, en = 1.
  - Required, ch0: count 20 with tc = 0, then 19.
  - Stimulus, all channels: assert rst for one cycle while all channels are enabled.
  - Required: all count/tc/ovf = 0 on the next edge.
- Channel independence:
  - Stimulus: all 4 channels enabled with differing dir/sat/max_val (3, 7, 255, 0).
  - Required: each count sequence matches its own scalar model.
  - Required: ch3 stays 0 with tc continuously high; ch2 wraps 255 → 0 with tc.
